// File: rtl/wb_stage_pipe.sv
// rtl/wb_stage_pipe.sv - writeback stage: source mux, load formatting, registered valid/ready output
//
// Parameters: XLEN (32 or 64), NUM_SRC (>= 4), SEL_W, LOAD_SRC_IDX.
// Optional build macro: WB_RETIRE_CNT_EN adds RETIRE_CLR / RETIRE_CNT.
//
// Ports:
//   WB_CLK, WB_RST_N            clock, asynchronous active-low reset
//   IN_VALID / IN_READY         upstream handshake from the memory stage
//   SRC_DATA                    NUM_SRC flattened XLEN-wide sources
//   RF_WR_SEL                   source select (out-of-range selects give 0)
//   RD_ADDR, RF_WE_IN           destination register and its write request
//   MEM_SIZE, MEM_UNS, ADDR_LO  load size, zero-extend flag, byte-lane offset
//   FLUSH                       kills the held entry and the incoming entry
//   OUT_READY / OUT_VALID       downstream handshake toward the register file
//   WD, WA, WE                  register-file write data, address, enable
//   RETIRE_CLR, RETIRE_CNT      retire counter clear and value (optional)

module wb_stage_pipe #(
    parameter int XLEN         = 32,
    parameter int NUM_SRC      = 4,
    parameter int SEL_W        = $clog2(NUM_SRC),
    parameter int LOAD_SRC_IDX = 2
) (
    input  logic                    WB_CLK,
    input  logic                    WB_RST_N,
`ifdef WB_RETIRE_CNT_EN
    input  logic                    RETIRE_CLR,
    output logic [63:0]             RETIRE_CNT,
`endif
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [NUM_SRC*XLEN-1:0] SRC_DATA,
    input  logic [SEL_W-1:0]        RF_WR_SEL,
    input  logic [4:0]              RD_ADDR,
    input  logic                    RF_WE_IN,
    input  logic [1:0]              MEM_SIZE,
    input  logic                    MEM_UNS,
    input  logic [1:0]              ADDR_LO,
    input  logic                    FLUSH,
    input  logic                    OUT_READY,
    output logic                    OUT_VALID,
    output logic [XLEN-1:0]         WD,
    output logic [4:0]              WA,
    output logic                    WE
);

    localparam logic [SEL_W-1:0] LOAD_SEL = SEL_W'(LOAD_SRC_IDX);

    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] fmt;
    logic [7:0]      byte_lane;
    logic [15:0]     half_lane;
    logic            accept;

    // A select with no matching slot falls through to the zero default.
    always_comb begin
        raw = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (RF_WR_SEL == SEL_W'(k)) begin
                raw = SRC_DATA[k*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        byte_lane = raw[7:0];
        case (ADDR_LO)
            2'd0:    byte_lane = raw[7:0];
            2'd1:    byte_lane = raw[15:8];
            2'd2:    byte_lane = raw[23:16];
            default: byte_lane = raw[31:24];
        endcase
    end

    // Halfword lanes are selected by ADDR_LO[1] only; misaligned halves are not split.
    assign half_lane = ADDR_LO[1] ? raw[31:16] : raw[15:0];

    // Size casts of signed operands sign-extend; unsigned operands zero-extend.
    always_comb begin
        fmt = raw;
        if (RF_WR_SEL == LOAD_SEL) begin
            case (MEM_SIZE)
                2'b00:   fmt = MEM_UNS ? XLEN'(byte_lane) : XLEN'($signed(byte_lane));
                2'b01:   fmt = MEM_UNS ? XLEN'(half_lane) : XLEN'($signed(half_lane));
                default: fmt = MEM_UNS ? XLEN'(raw[31:0]) : XLEN'($signed(raw[31:0]));
            endcase
        end
    end

    assign IN_READY = !OUT_VALID || OUT_READY;
    assign accept   = IN_VALID && IN_READY;

    // FLUSH outranks both accept and consume. WD/WA are left as they were
    // whenever the entry leaves, only the valid and enable drop.
    always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
        if (!WB_RST_N) begin
            OUT_VALID <= 1'b0;
            WD        <= '0;
            WA        <= '0;
            WE        <= 1'b0;
        end else if (FLUSH) begin
            OUT_VALID <= 1'b0;
            WE        <= 1'b0;
        end else if (accept) begin
            OUT_VALID <= 1'b1;
            WD        <= fmt;
            WA        <= RD_ADDR;
            WE        <= RF_WE_IN && (RD_ADDR != 5'd0);
        end else if (OUT_VALID && OUT_READY) begin
            OUT_VALID <= 1'b0;
            WE        <= 1'b0;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    // A held entry that is consumed on the same edge a FLUSH arrives has
    // already been taken downstream, so it still retires; the flushed
    // incoming entry never reaches OUT_VALID and so never counts.
    always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
        if (!WB_RST_N) begin
            RETIRE_CNT <= '0;
        end else if (RETIRE_CLR) begin
            RETIRE_CNT <= '0;
        end else if (OUT_VALID && OUT_READY) begin
            RETIRE_CNT <= RETIRE_CNT + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// tb/tb_wb_stage_pipe.sv - self-checking bench for wb_stage_pipe

module tb_wb_stage_pipe;

    localparam int XLEN = 32;
    localparam int NS   = 5;
    localparam int SW   = 3;

    logic            WB_CLK = 1'b0;
    logic            WB_RST_N;
    logic            IN_VALID;
    logic            IN_READY;
    logic [NS*XLEN-1:0] SRC_DATA;
    logic [SW-1:0]   RF_WR_SEL;
    logic [4:0]      RD_ADDR;
    logic            RF_WE_IN;
    logic [1:0]      MEM_SIZE;
    logic            MEM_UNS;
    logic [1:0]      ADDR_LO;
    logic            FLUSH;
    logic            OUT_READY;
    logic            OUT_VALID;
    logic [XLEN-1:0] WD;
    logic [4:0]      WA;
    logic            WE;
`ifdef WB_RETIRE_CNT_EN
    logic            RETIRE_CLR;
    logic [63:0]     RETIRE_CNT;
`endif

    int tests = 0;
    int fails = 0;

    wb_stage_pipe #(.XLEN(XLEN), .NUM_SRC(NS), .SEL_W(SW), .LOAD_SRC_IDX(2)) dut (
        .WB_CLK(WB_CLK), .WB_RST_N(WB_RST_N),
`ifdef WB_RETIRE_CNT_EN
        .RETIRE_CLR(RETIRE_CLR), .RETIRE_CNT(RETIRE_CNT),
`endif
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .SRC_DATA(SRC_DATA),
        .RF_WR_SEL(RF_WR_SEL), .RD_ADDR(RD_ADDR), .RF_WE_IN(RF_WE_IN),
        .MEM_SIZE(MEM_SIZE), .MEM_UNS(MEM_UNS), .ADDR_LO(ADDR_LO), .FLUSH(FLUSH),
        .OUT_READY(OUT_READY), .OUT_VALID(OUT_VALID), .WD(WD), .WA(WA), .WE(WE)
    );

    always #5 WB_CLK = ~WB_CLK;

    task automatic tick();
        @(posedge WB_CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [SW-1:0] sel, input logic [4:0] rd,
                         input logic we, input logic [1:0] sz, input logic u,
                         input logic [1:0] lo, input logic fl, input logic ord);
        IN_VALID  = v;
        RF_WR_SEL = sel;
        RD_ADDR   = rd;
        RF_WE_IN  = we;
        MEM_SIZE  = sz;
        MEM_UNS   = u;
        ADDR_LO   = lo;
        FLUSH     = fl;
        OUT_READY = ord;
    endtask

    // Reference: pick the slot, shift the addressed lane down, mask, then
    // sign-extend by subtracting 2^width when the top bit is set.
    function automatic logic [31:0] ref_wd(input int sel, input logic [NS*XLEN-1:0] src,
                                           input logic [1:0] sz, input logic u, input logic [1:0] lo);
        longint v;
        int     width;
        int     sh;
        if (sel >= NS) return 32'h0;
        v = longint'(src[sel*XLEN +: XLEN]);
        if (sel != 2) return v[31:0];
        if (sz == 2'b00) begin width = 8;  sh = 8 * int'(lo); end
        else if (sz == 2'b01) begin width = 16; sh = 16 * (int'(lo) / 2); end
        else begin width = 32; sh = 0; end
        v = (v >> sh) & ((longint'(1) << width) - 1);
        if (!u && v >= (longint'(1) << (width - 1))) v = v - (longint'(1) << width);
        return v[31:0];
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge WB_CLK);
        #1;
        tests++; if (OUT_VALID !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", OUT_VALID); end
        tests++; if (WD !== 32'h0) begin fails++; $display("FAIL reset_wd got=%h exp=0", WD); end
        tests++; if (WA !== 5'h0) begin fails++; $display("FAIL reset_wa got=%h exp=0", WA); end
        tests++; if (WE !== 1'b0) begin fails++; $display("FAIL reset_we got=%b exp=0", WE); end
        tests++; if (IN_READY !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", IN_READY); end
        WB_RST_N = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        SRC_DATA = {$urandom, $urandom, $urandom, $urandom, $urandom};
        SRC_DATA[3*XLEN +: XLEN] = 32'h0000_1234;
        drive(1, 3, 5, 1, 2'b10, 0, 0, 0, 1);
        tick();
        drive(0, 3, 5, 1, 2'b10, 0, 0, 0, 1);
        tests++; if (OUT_VALID !== 1'b1) begin fails++; $display("FAIL alu_valid got=%b exp=1", OUT_VALID); end
        tests++; if (WD !== 32'h0000_1234) begin fails++; $display("FAIL alu_wd got=%h exp=00001234", WD); end
        tests++; if (WA !== 5'd5) begin fails++; $display("FAIL alu_wa got=%0d exp=5", WA); end
        tests++; if (WE !== 1'b1) begin fails++; $display("FAIL alu_we got=%b exp=1", WE); end
        tick();
        tests++; if (OUT_VALID !== 1'b0) begin fails++; $display("FAIL alu_drain_valid got=%b exp=0", OUT_VALID); end
        tests++; if (WE !== 1'b0) begin fails++; $display("FAIL alu_drain_we got=%b exp=0", WE); end
        drive(1, 3, 0, 1, 2'b10, 0, 0, 0, 1);
        tick();
        drive(0, 3, 0, 1, 2'b10, 0, 0, 0, 1);
        tests++; if (OUT_VALID !== 1'b1) begin fails++; $display("FAIL rd0_valid got=%b exp=1", OUT_VALID); end
        tests++; if (WE !== 1'b0) begin fails++; $display("FAIL rd0_we got=%b exp=0", WE); end
        tick();
    endtask

    task automatic test_load();
        logic [1:0]  sz_t [4] = '{2'b00, 2'b00, 2'b00, 2'b01};
        logic        u_t  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0]  lo_t [4] = '{2'd0, 2'd0, 2'd2, 2'd3};
        logic [31:0] ex_t [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_FFFF, 32'hFFFF_80FF};
        SRC_DATA[2*XLEN +: XLEN] = 32'h80FF_7F80;
        for (int i = 0; i < 4; i++) begin
            drive(1, 2, 5'(i + 1), 1, sz_t[i], u_t[i], lo_t[i], 0, 1);
            tick();
            tests++; if (WD !== ex_t[i] || OUT_VALID !== 1'b1) begin
                fails++; $display("FAIL load_%0d wd=%h valid=%b exp wd=%h valid=1", i, WD, OUT_VALID, ex_t[i]);
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
    endtask

    task automatic test_stall();
        SRC_DATA[3*XLEN +: XLEN] = 32'hAAAA_0001;
        drive(1, 3, 7, 1, 2'b10, 0, 0, 0, 0);
        tick();
        SRC_DATA[3*XLEN +: XLEN] = 32'hBBBB_0002;
        drive(1, 3, 9, 1, 2'b10, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++; if (IN_READY !== 1'b0) begin fails++; $display("FAIL stall_in_ready_%0d got=%b exp=0", c, IN_READY); end
            tests++; if (OUT_VALID !== 1'b1 || WD !== 32'hAAAA_0001 || WA !== 5'd7) begin
                fails++; $display("FAIL stall_hold_%0d valid=%b wd=%h wa=%0d exp 1/aaaa0001/7", c, OUT_VALID, WD, WA);
            end
            tick();
        end
        drive(1, 3, 9, 1, 2'b10, 0, 0, 0, 1);
        #1;
        tests++; if (IN_READY !== 1'b1) begin fails++; $display("FAIL release_in_ready got=%b exp=1", IN_READY); end
        tick();
        drive(0, 3, 9, 1, 2'b10, 0, 0, 0, 1);
        tests++; if (OUT_VALID !== 1'b1 || WD !== 32'hBBBB_0002 || WA !== 5'd9) begin
            fails++; $display("FAIL release_entry valid=%b wd=%h wa=%0d exp 1/bbbb0002/9", OUT_VALID, WD, WA);
        end
        tick();
        tests++; if (OUT_VALID !== 1'b0) begin fails++; $display("FAIL release_no_dup got=%b exp=0", OUT_VALID); end
    endtask

    task automatic test_flush();
        SRC_DATA[3*XLEN +: XLEN] = 32'h1111_0004;
        drive(1, 3, 3, 1, 2'b10, 0, 0, 0, 0);
        tick();
        tests++; if (OUT_VALID !== 1'b1) begin fails++; $display("FAIL flush_pre_valid got=%b exp=1", OUT_VALID); end
        SRC_DATA[3*XLEN +: XLEN] = 32'hDEAD_0003;
        drive(1, 3, 11, 1, 2'b10, 0, 0, 1, 1);
        tick();
        drive(0, 3, 11, 1, 2'b10, 0, 0, 0, 1);
        tests++; if (OUT_VALID !== 1'b0 || WE !== 1'b0) begin
            fails++; $display("FAIL flush_kill valid=%b we=%b exp 0/0", OUT_VALID, WE);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            tests++; if (OUT_VALID !== 1'b0 || WD === 32'hDEAD_0003) begin
                fails++; $display("FAIL flush_never_presented valid=%b wd=%h exp valid=0", OUT_VALID, WD);
            end
        end
    endtask

    task automatic test_async_reset();
        SRC_DATA[3*XLEN +: XLEN] = 32'h5555_AAAA;
        drive(1, 3, 13, 1, 2'b10, 0, 0, 0, 0);
        tick();
        tests++; if (OUT_VALID !== 1'b1) begin fails++; $display("FAIL areset_pre_valid got=%b exp=1", OUT_VALID); end
        #2;
        WB_RST_N = 1'b0;
        #1;
        tests++; if (OUT_VALID !== 1'b0 || WD !== 32'h0 || WA !== 5'h0 || WE !== 1'b0) begin
            fails++; $display("FAIL areset_async valid=%b wd=%h wa=%h we=%b exp all 0", OUT_VALID, WD, WA, WE);
        end
        tick();
        tests++; if (OUT_VALID !== 1'b0) begin fails++; $display("FAIL areset_hold got=%b exp=0", OUT_VALID); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        WB_RST_N = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic        m_valid = 1'b0;
        logic [31:0] m_wd = '0;
        logic [4:0]  m_wa = '0;
        logic        m_we = 1'b0;
        logic [SW-1:0] sel;
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < NS; k++) SRC_DATA[k*XLEN +: XLEN] = $urandom;
            sel = ($urandom_range(0, 1) == 0) ? SW'(2) : SW'($urandom_range(0, 7));
            drive($urandom_range(0, 3) != 0, sel, 5'($urandom_range(0, 31)), 1'($urandom),
                  2'($urandom), 1'($urandom), 2'($urandom), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 2) != 0);
            #1;
            tests++; if (IN_READY !== (!m_valid || OUT_READY)) begin
                fails++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", n, IN_READY, !m_valid || OUT_READY);
            end
            tests++; if (OUT_VALID !== m_valid || WE !== (m_valid && m_we) ||
                         (m_valid && (WD !== m_wd || WA !== m_wa))) begin
                fails++; $display("FAIL rnd_out cyc=%0d valid=%b wd=%h wa=%0d we=%b exp %b/%h/%0d/%b",
                                  n, OUT_VALID, WD, WA, WE, m_valid, m_wd, m_wa, m_valid && m_we);
            end
            if (FLUSH) begin
                m_valid = 1'b0;
            end else if (IN_VALID && (!m_valid || OUT_READY)) begin
                m_valid = 1'b1;
                m_wd    = ref_wd(int'(RF_WR_SEL), SRC_DATA, MEM_SIZE, MEM_UNS, ADDR_LO);
                m_wa    = RD_ADDR;
                m_we    = RF_WE_IN && RD_ADDR != 0;
            end else if (OUT_READY) begin
                m_valid = 1'b0;
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
    endtask

`ifdef WB_RETIRE_CNT_EN
    task automatic test_retire();
        longint exp_cnt = 0;
        RETIRE_CLR = 1'b1;
        tick();
        RETIRE_CLR = 1'b0;
        tests++; if (RETIRE_CNT !== 64'd0) begin fails++; $display("FAIL retire_clear got=%0d exp=0", RETIRE_CNT); end
        for (int i = 0; i < 10; i++) begin
            drive(1, 3, 5'(i + 1), 1, 2'b10, 0, 0, i == 4, 1);
            if (i != 4) exp_cnt++;
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        tests++; if (RETIRE_CNT !== 64'(exp_cnt)) begin
            fails++; $display("FAIL retire_count got=%0d exp=%0d", RETIRE_CNT, exp_cnt);
        end
        drive(1, 3, 1, 1, 2'b10, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        RETIRE_CLR = 1'b1;
        tick();
        RETIRE_CLR = 1'b0;
        tests++; if (RETIRE_CNT !== 64'd0) begin fails++; $display("FAIL retire_clr_wins got=%0d exp=0", RETIRE_CNT); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        WB_RST_N = 1'b0;
        SRC_DATA = '0;
`ifdef WB_RETIRE_CNT_EN
        RETIRE_CLR = 1'b0;
`endif
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        test_reset();
        test_alu();
        test_load();
        test_stall();
        test_flush();
        test_async_reset();
        test_random();
`ifdef WB_RETIRE_CNT_EN
        test_retire();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
